// File: rtl/mpt_mem_arbiter.sv
// Purpose: round-robin (or fixed-priority with MPT_MEM_ARB_FIXED_PRIO_EN) arbiter sharing one memory port among walkers.
// Latency: grant is combinational from downstream gnt; responses are routed in order with zero added latency.
// Backpressure: a stalled request locks its requester until granted; issue stops at MAX_OUTSTANDING in flight.

// In-order FIFO with a show-ahead head; pushes at full and pops at empty are ignored.
module mpt_mem_arb_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_vld,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_vld && (count != CW'(DEPTH));
    assign do_pop  = pop_vld && (count != '0);
    assign pop_dat = mem[rd_ptr];

    // Storage is not reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap at DEPTH so non power-of-two depths work; count tracks occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module mpt_mem_arbiter #(
    parameter int NUM_REQUESTERS    = 3,
    parameter int MEMORY_DATA_WIDTH = 64,
    parameter int MEMORY_ADDR_WIDTH = 64,
    parameter int MAX_OUTSTANDING   = 4
) (
    input  logic                                                clk_i,
    input  logic                                                rst_ni,
    input  logic [NUM_REQUESTERS-1:0]                           req_mem_req,
    output logic [NUM_REQUESTERS-1:0]                           req_mem_gnt,
    output logic [NUM_REQUESTERS-1:0]                           req_mem_valid,
    input  logic [NUM_REQUESTERS-1:0][MEMORY_ADDR_WIDTH-1:0]    req_mem_addr,
    input  logic [NUM_REQUESTERS-1:0][MEMORY_DATA_WIDTH-1:0]    req_mem_wdata,
    input  logic [NUM_REQUESTERS-1:0]                           req_mem_we,
    input  logic [NUM_REQUESTERS-1:0][MEMORY_DATA_WIDTH/8-1:0]  req_mem_be,
    output logic [NUM_REQUESTERS-1:0][MEMORY_DATA_WIDTH-1:0]    req_mem_rdata,
    output logic [NUM_REQUESTERS-1:0]                           req_mem_error,
    output logic                                                memory_master_mem_req,
    input  logic                                                memory_master_mem_gnt,
    input  logic                                                memory_master_mem_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]                        memory_master_mem_addr,
    input  logic [MEMORY_DATA_WIDTH-1:0]                        memory_master_mem_rdata,
    output logic [MEMORY_DATA_WIDTH-1:0]                        memory_master_mem_wdata,
    output logic                                                memory_master_mem_we,
    output logic [MEMORY_DATA_WIDTH/8-1:0]                      memory_master_mem_be,
    input  logic                                                memory_master_mem_error,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]                outstanding_o
);
    localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    logic [IW-1:0] locked_idx;
    logic [IW-1:0] arb_idx;
    logic          arb_any;
    logic [IW-1:0] sel_idx;
    logic          sel_vld;
    logic          use_lock;
    logic          full;
    logic          handshake;
    logic          pop;
    logic [IW-1:0] head_idx;
    logic [CW-1:0] count;

`ifndef MPT_MEM_ARB_FIXED_PRIO_EN
    logic [IW-1:0] rr_ptr;
    logic [IW:0]   cand;
`endif

    assign full      = (count == CW'(MAX_OUTSTANDING));
    assign handshake = memory_master_mem_req && memory_master_mem_gnt;
    assign pop       = rst_ni && memory_master_mem_valid && (count != '0);

    // Every request-side output is forced low while reset is asserted, even with active inputs.
    assign memory_master_mem_req = rst_ni && (|req_mem_req) && !full;
    assign outstanding_o         = count;

`ifdef MPT_MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest requesting index wins.
    always_comb begin
        arb_idx = '0;
        arb_any = 1'b0;
        for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
            if (req_mem_req[k]) begin
                arb_idx = IW'(k);
                arb_any = 1'b1;
            end
        end
    end
`else
    // Round robin: first requester at or after rr_ptr, searching cyclically.
    always_comb begin
        arb_idx = '0;
        arb_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            cand = {1'b0, rr_ptr} + (IW + 1)'(k);
            if (cand >= (IW + 1)'(NUM_REQUESTERS)) begin
                cand = cand - (IW + 1)'(NUM_REQUESTERS);
            end
            if (!arb_any && req_mem_req[cand[IW-1:0]]) begin
                arb_idx = cand[IW-1:0];
                arb_any = 1'b1;
            end
        end
    end

    // Pointer advances past the winner on every accepted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (sel_idx == IW'(NUM_REQUESTERS - 1)) ? '0 : sel_idx + IW'(1);
        end
    end
`endif

    // A stalled requester keeps the port until granted; if it withdraws, arbitration resumes.
    always_comb begin
        use_lock = (state == LOCKED) && req_mem_req[locked_idx];
        sel_idx  = use_lock ? locked_idx : arb_idx;
        sel_vld  = rst_ni && (use_lock || arb_any);
    end

    // Mux the selected requester onto the shared port; all zero when nobody is selected.
    always_comb begin
        memory_master_mem_addr  = '0;
        memory_master_mem_wdata = '0;
        memory_master_mem_we    = 1'b0;
        memory_master_mem_be    = '0;
        if (sel_vld) begin
            memory_master_mem_addr  = req_mem_addr[sel_idx];
            memory_master_mem_wdata = req_mem_wdata[sel_idx];
            memory_master_mem_we    = req_mem_we[sel_idx];
            memory_master_mem_be    = req_mem_be[sel_idx];
        end
    end

    // Grants follow the downstream handshake in the same cycle; responses go to the oldest ID.
    always_comb begin
        req_mem_gnt   = '0;
        req_mem_valid = '0;
        req_mem_error = '0;
        req_mem_rdata = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            req_mem_gnt[i]   = handshake && (sel_idx == IW'(i));
            req_mem_valid[i] = pop && (head_idx == IW'(i));
            req_mem_error[i] = pop && (head_idx == IW'(i)) && memory_master_mem_error;
            req_mem_rdata[i] = rst_ni ? memory_master_mem_rdata : '0;
        end
    end

    // Lock FSM: enter LOCKED on a stalled request, leave on handshake or when the request vanishes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            locked_idx <= '0;
        end else if (handshake) begin
            state <= IDLE;
        end else if (memory_master_mem_req) begin
            state      <= LOCKED;
            locked_idx <= sel_idx;
        end else begin
            state <= IDLE;
        end
    end

    mpt_mem_arb_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (handshake),
        .push_dat (sel_idx),
        .pop_vld  (pop),
        .pop_dat  (head_idx),
        .count    (count)
    );
endmodule

// File: tb/tb_mpt_mem_arbiter.sv
// Purpose: self-checking bench for mpt_mem_arbiter with directed scenarios and a queue-based reference model.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1ns later.
// Backpressure: downstream gnt/valid are driven directly by the bench.
module tb_mpt_mem_arbiter;
    localparam int N  = 3;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int MO = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic [N-1:0]         req = '0;
    logic [N-1:0]         gnt_out;
    logic [N-1:0]         vld_out;
    logic [N-1:0][AW-1:0] addr = '0;
    logic [N-1:0][DW-1:0] wdata = '0;
    logic [N-1:0]         we = '0;
    logic [N-1:0][DW/8-1:0] be = '0;
    logic [N-1:0][DW-1:0] rdata_out;
    logic [N-1:0]         err_out;
    logic                 mm_req;
    logic                 mm_gnt = 1'b0;
    logic                 mm_valid = 1'b0;
    logic [AW-1:0]        mm_addr;
    logic [DW-1:0]        mm_rdata = '0;
    logic [DW-1:0]        mm_wdata;
    logic                 mm_we;
    logic [DW/8-1:0]      mm_be;
    logic                 mm_error = 1'b0;
    logic [2:0]           outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int   m_rr;
    bit   m_locked;
    int   m_lidx;
    int   m_q[$];
    // Expected values for the current cycle
    int   e_sel;
    bit   e_mem_req;
    bit   e_hs;
    bit   e_pop;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_valid;
    logic [N-1:0] e_error;
    logic [AW+DW+1+DW/8-1:0] e_port;

    mpt_mem_arbiter #(
        .NUM_REQUESTERS    (N),
        .MEMORY_DATA_WIDTH (DW),
        .MEMORY_ADDR_WIDTH (AW),
        .MAX_OUTSTANDING   (MO)
    ) dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .req_mem_req             (req),
        .req_mem_gnt             (gnt_out),
        .req_mem_valid           (vld_out),
        .req_mem_addr            (addr),
        .req_mem_wdata           (wdata),
        .req_mem_we              (we),
        .req_mem_be              (be),
        .req_mem_rdata           (rdata_out),
        .req_mem_error           (err_out),
        .memory_master_mem_req   (mm_req),
        .memory_master_mem_gnt   (mm_gnt),
        .memory_master_mem_valid (mm_valid),
        .memory_master_mem_addr  (mm_addr),
        .memory_master_mem_rdata (mm_rdata),
        .memory_master_mem_wdata (mm_wdata),
        .memory_master_mem_we    (mm_we),
        .memory_master_mem_be    (mm_be),
        .memory_master_mem_error (mm_error),
        .outstanding_o           (outstanding)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t limit 2000000", $time);
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; mm_gnt = 1'b0; mm_valid = 1'b0; mm_error = 1'b0; mm_rdata = '0;
    endtask

    task automatic model_reset();
        m_rr = 0; m_locked = 0; m_lidx = 0; m_q.delete();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
    endtask

    // Expected outputs from the arbitration rules, given current inputs and model state.
    task automatic model_eval();
        e_sel = -1;
        e_mem_req = (req != '0) && (m_q.size() < MO);
        if (m_locked && req[m_lidx]) begin
            e_sel = m_lidx;
        end else begin
            for (int k = 0; k < N; k++) begin
`ifdef MPT_MEM_ARB_FIXED_PRIO_EN
                int j = k;
`else
                int j = (m_rr + k) % N;
`endif
                if (e_sel < 0 && req[j]) e_sel = j;
            end
        end
        e_hs    = e_mem_req && mm_gnt;
        e_gnt   = e_hs ? N'(1 << e_sel) : '0;
        e_pop   = mm_valid && (m_q.size() > 0);
        e_valid = e_pop ? N'(1 << m_q[0]) : '0;
        e_error = (e_pop && mm_error) ? e_valid : '0;
        e_port  = (e_sel >= 0) ? {addr[e_sel], wdata[e_sel], we[e_sel], be[e_sel]} : '0;
    endtask

    task automatic model_commit();
        if (e_pop) void'(m_q.pop_front());
        if (e_hs) begin
            m_q.push_back(e_sel);
            m_rr = (e_sel + 1) % N;
            m_locked = 0;
        end else if (e_mem_req) begin
            m_locked = 1;
            m_lidx = e_sel;
        end else begin
            m_locked = 0;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req = '1; mm_gnt = 1'b1; mm_valid = 1'b1; mm_error = 1'b1; mm_rdata = 64'hDEAD_BEEF_0123_4567;
        addr[0] = 64'h1234; wdata[0] = 64'h5678; we = '1; be = '1;
        #3;
        n_tests++;
        if ({gnt_out, vld_out, err_out, mm_req, outstanding} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0", {gnt_out, vld_out, err_out, mm_req, outstanding});
        end
        n_tests++;
        if ({mm_addr, mm_wdata, mm_we, mm_be} !== '0 || rdata_out !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr %h rdata %h expected 0", mm_addr, rdata_out);
        end
        do_reset();
        n_tests++;
        if (outstanding !== 3'd0 || mm_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got out %0d req %b expected 0 0", outstanding, mm_req);
        end
    endtask

    task automatic test_round_robin();
        int exp_idx;
        int prev_idx;
        do_reset();
        req = 3'b111; mm_gnt = 1'b1;
        prev_idx = 0;
        for (int k = 0; k < 6; k++) begin
`ifdef MPT_MEM_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = k % 3;
`endif
            mm_valid = (k != 0);
            #1;
            n_tests++;
            if (gnt_out !== N'(1 << exp_idx)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", k, gnt_out, N'(1 << exp_idx));
            end
            if (k != 0) begin
                n_tests++;
                if (vld_out !== N'(1 << prev_idx) || outstanding !== 3'd1) begin
                    n_fail++;
                    $display("FAIL rr_resp[%0d]: got valid %b out %0d expected %b 1", k, vld_out, outstanding, N'(1 << prev_idx));
                end
            end
            prev_idx = exp_idx;
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        addr[0] = 64'hA0A0_0000_0000_00A0; addr[1] = 64'hB1B1_0000_0000_00B1; addr[2] = 64'hC2C2_0000_0000_00C2;
        for (int c = 1; c <= 5; c++) begin
            req    = (c == 1) ? 3'b010 : (c == 5) ? 3'b001 : 3'b011;
            mm_gnt = (c >= 4);
            #1;
            n_tests++;
            if (c < 5 && (mm_addr !== addr[1] || gnt_out !== ((c == 4) ? 3'b010 : 3'b000))) begin
                n_fail++;
                $display("FAIL lock_cycle%0d: got addr %h gnt %b expected %h %b", c, mm_addr, gnt_out, addr[1], (c == 4) ? 3'b010 : 3'b000);
            end else if (c == 5 && (mm_addr !== addr[0] || gnt_out !== 3'b001)) begin
                n_fail++;
                $display("FAIL lock_next: got addr %h gnt %b expected %h 001", mm_addr, gnt_out, addr[0]);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        req = 3'b001; mm_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++;
            if (gnt_out !== 3'b001 || outstanding !== 3'(k)) begin
                n_fail++;
                $display("FAIL full_fill[%0d]: got gnt %b out %0d expected 001 %0d", k, gnt_out, outstanding, k);
            end
            next_cycle();
        end
        #1;
        n_tests++;
        if (mm_req !== 1'b0 || outstanding !== 3'd4 || gnt_out !== 3'b000) begin
            n_fail++;
            $display("FAIL full_stop: got req %b out %0d gnt %b expected 0 4 000", mm_req, outstanding, gnt_out);
        end
        next_cycle();
        mm_valid = 1'b1;
        #1;
        n_tests++;
        if (mm_req !== 1'b0 || vld_out !== 3'b001) begin
            n_fail++;
            $display("FAIL full_pop_cycle: got req %b valid %b expected 0 001", mm_req, vld_out);
        end
        next_cycle();
        mm_valid = 1'b0;
        #1;
        n_tests++;
        if (mm_req !== 1'b1 || outstanding !== 3'd3 || gnt_out !== 3'b001) begin
            n_fail++;
            $display("FAIL full_resume: got req %b out %0d gnt %b expected 1 3 001", mm_req, outstanding, gnt_out);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_error_order();
        logic [N-1:0] reqs  [3];
        logic         errs  [3];
        logic [N-1:0] exp_e [3];
        reqs[0] = 3'b100; reqs[1] = 3'b001; reqs[2] = 3'b010;
        errs[0] = 1'b0;   errs[1] = 1'b1;   errs[2] = 1'b0;
        exp_e[0] = 3'b000; exp_e[1] = 3'b001; exp_e[2] = 3'b000;
        do_reset();
        mm_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req = reqs[k];
            #1;
            n_tests++;
            if (gnt_out !== reqs[k]) begin
                n_fail++;
                $display("FAIL order_grant[%0d]: got %b expected %b", k, gnt_out, reqs[k]);
            end
            next_cycle();
        end
        req = '0; mm_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mm_valid = 1'b1; mm_error = errs[k];
            #1;
            n_tests++;
            if (vld_out !== reqs[k] || err_out !== exp_e[k]) begin
                n_fail++;
                $display("FAIL order_resp[%0d]: got valid %b err %b expected %b %b", k, vld_out, err_out, reqs[k], exp_e[k]);
            end
            next_cycle();
        end
        clear_inputs();
        #1;
        n_tests++;
        if (outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL order_drain: got %0d expected 0", outstanding);
        end
        next_cycle();
    endtask

    task automatic test_spurious();
        logic [DW-1:0] rd;
        do_reset();
        rd = {$urandom, $urandom};
        mm_valid = 1'b1; mm_rdata = rd;
        #1;
        n_tests++;
        if (vld_out !== 3'b000 || outstanding !== 3'd0 || rdata_out !== {N{rd}}) begin
            n_fail++;
            $display("FAIL spurious: got valid %b out %0d rdata0 %h expected 000 0 %h", vld_out, outstanding, rdata_out[0], rd);
        end
        next_cycle();
        mm_valid = 1'b0;
        #1;
        n_tests++;
        if (outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL spurious_count: got %0d expected 0", outstanding);
        end
        next_cycle();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        req = 3'b001; mm_gnt = 1'b1;
        repeat (3) next_cycle();
        req = 3'b111; mm_valid = 1'b1; mm_error = 1'b1; mm_rdata = 64'hFACE_CAFE_1111_2222;
        #1;
        n_tests++;
        if (outstanding !== 3'd3) begin
            n_fail++;
            $display("FAIL inflight_pre: got %0d expected 3", outstanding);
        end
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if ({gnt_out, vld_out, err_out, mm_req, outstanding} !== 13'd0 || mm_addr !== '0 || rdata_out !== '0) begin
            n_fail++;
            $display("FAIL inflight_reset: got %b addr %h expected 0", {gnt_out, vld_out, err_out, mm_req, outstanding}, mm_addr);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        req = '0; mm_gnt = 1'b0; mm_error = 1'b0;
        #1;
        n_tests++;
        if (vld_out !== 3'b000 || outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL inflight_late: got valid %b out %0d expected 000 0", vld_out, outstanding);
        end
        next_cycle();
        mm_valid = 1'b0; req = 3'b111; mm_gnt = 1'b1;
        #1;
        n_tests++;
        if (gnt_out !== 3'b001 || outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL inflight_idle: got gnt %b out %0d expected 001 0", gnt_out, outstanding);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req      = N'($urandom_range(0, 7));
            mm_gnt   = ($urandom_range(0, 3) != 0);
            mm_valid = ($urandom_range(0, 1) != 0);
            mm_error = ($urandom_range(0, 3) == 0);
            mm_rdata = {$urandom, $urandom};
            for (int i = 0; i < N; i++) begin
                addr[i]  = {$urandom, $urandom};
                wdata[i] = {$urandom, $urandom};
                we[i]    = $urandom_range(0, 1) != 0;
                be[i]    = 8'($urandom);
            end
            #1;
            model_eval();
            n_tests++;
            if ({gnt_out, vld_out, err_out, mm_req, outstanding} !== {e_gnt, e_valid, e_error, e_mem_req, 3'(m_q.size())}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got %b expected %b", c, {gnt_out, vld_out, err_out, mm_req, outstanding},
                         {e_gnt, e_valid, e_error, e_mem_req, 3'(m_q.size())});
            end
            n_tests++;
            if ({mm_addr, mm_wdata, mm_we, mm_be} !== e_port || rdata_out !== {N{mm_rdata}}) begin
                n_fail++;
                $display("FAIL rand_port[%0d]: got addr %h expected %h", c, mm_addr, e_port[AW+DW+1+DW/8-1 -: AW]);
            end
            model_commit();
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_error_order();
        test_spurious();
        test_reset_inflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
